// File: rtl/series_pkg.sv
// Shared types and default widths for the series-engine job dispatcher.
package series_pkg;
  localparam int XW_DEF     = 8;
  localparam int YW_DEF     = 8;
  localparam int RW_DEF     = 17;
  localparam int JOBS_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE
  } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count and registered full/non-empty flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             nonempty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             wr_en;
  logic             rd_en;

  assign wr_en = push && !full;
  assign rd_en = pop && nonempty;

  always_comb begin
    count_nxt = count;
    if (wr_en && !rd_en)
      count_nxt = count + CW'(1);
    else if (!wr_en && rd_en)
      count_nxt = count - CW'(1);
  end

  // Flags derive from the next count so they are registered, not decoded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      nonempty <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (rd_en) rptr <= rptr + AW'(1);
      count    <= count_nxt;
      full     <= (count_nxt == CW'(DEPTH));
      nonempty <= (count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wdata;
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign rdata = nonempty ? mem[rptr] : '0;
endmodule

// File: rtl/series_job_dispatcher.sv
// Queues (x, y) jobs, launches the series engine one at a time and
// returns each signed engine result through a result queue.
module series_job_dispatcher
  import series_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int RW    = RW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  input  logic [XW-1:0]          job_x,
  input  logic [YW-1:0]          job_y,
  output logic                   job_ready,
  output logic                   res_valid,
  output logic signed [RW-1:0]   res_data,
  input  logic                   res_ready,
  output logic                   eng_start,
  output logic [XW-1:0]          eng_x,
  output logic [YW-1:0]          eng_y,
  input  logic                   eng_ready,
  input  logic signed [RW-1:0]   eng_result,
  output logic                   busy,
  output logic [JOBS_CNT_W-1:0]  jobs_done
);
  state_t           state;
  logic [XW+YW-1:0] job_head;
  logic [RW-1:0]    res_head;
  logic             job_full;
  logic             job_nonempty;
  logic             res_full;
  logic             res_nonempty;
  logic             launch_ok;
  logic             job_pop;
  logic             res_push;

  sync_fifo #(.WIDTH(XW + YW), .DEPTH(DEPTH)) u_job_q (
    .clk      (clk),
    .rst      (rst),
    .push     (job_valid),
    .wdata    ({job_x, job_y}),
    .pop      (job_pop),
    .rdata    (job_head),
    .full     (job_full),
    .nonempty (job_nonempty)
  );

  sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_res_q (
    .clk      (clk),
    .rst      (rst),
    .push     (res_push),
    .wdata    (eng_result),
    .pop      (res_ready),
    .rdata    (res_head),
    .full     (res_full),
    .nonempty (res_nonempty)
  );

  assign job_ready = !job_full;
  assign res_valid = res_nonempty;
  assign res_data  = res_head;

  // At most one job is ever in flight and none is in flight in IDLE, so the
  // result-slot reservation reduces to the result queue not being full.
  assign launch_ok = job_nonempty && eng_ready && !res_full;
  assign job_pop   = (state == IDLE) && launch_ok;
  assign res_push  = (state == WAIT_DONE) && eng_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      eng_start <= 1'b0;
      eng_x     <= '0;
      eng_y     <= '0;
      busy      <= 1'b0;
      jobs_done <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch_ok) begin
            state          <= LAUNCH;
            eng_start      <= 1'b1;
            {eng_x, eng_y} <= job_head;
            busy           <= 1'b1;
          end
        end
        LAUNCH: begin
          state     <= WAIT_ACK;
          eng_start <= 1'b0;
        end
        WAIT_ACK: begin
          if (!eng_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (eng_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            jobs_done <= jobs_done + JOBS_CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_series_job_dispatcher.sv
// Directed bench for series_job_dispatcher with a behavioural engine model.
module tb_series_job_dispatcher;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               job_valid = 1'b0;
  logic [7:0]         job_x = 8'h00;
  logic [7:0]         job_y = 8'h00;
  logic               job_ready;
  logic               res_valid;
  logic signed [16:0] res_data;
  logic               res_ready = 1'b0;
  logic               eng_start;
  logic [7:0]         eng_x;
  logic [7:0]         eng_y;
  logic               eng_ready;
  logic signed [16:0] eng_result;
  logic               busy;
  logic [7:0]         jobs_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  series_job_dispatcher dut (
    .clk        (clk),
    .rst        (rst),
    .job_valid  (job_valid),
    .job_x      (job_x),
    .job_y      (job_y),
    .job_ready  (job_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .eng_start  (eng_start),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_ready  (eng_ready),
    .eng_result (eng_result),
    .busy       (busy),
    .jobs_done  (jobs_done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Engine model: drops ready after sampling start (+ack_delay), stays busy
  // busy_time cycles, then returns the next queued result or {0, x}.
  logic        eng_rdy_m;
  logic        eng_hold = 1'b0;
  int          ack_delay = 0;
  int          busy_time = 20;
  int          ph;
  int          cnt;
  logic [16:0] eng_res_q[$];

  assign eng_ready = eng_rdy_m && !eng_hold;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_rdy_m  <= 1'b1;
      ph         <= 0;
      cnt        <= 0;
      eng_result <= '0;
    end else begin
      case (ph)
        0: if (eng_start) begin
          if (ack_delay == 0) begin
            eng_rdy_m <= 1'b0; cnt <= busy_time; ph <= 2;
          end else begin
            cnt <= ack_delay; ph <= 1;
          end
        end
        1: if (cnt <= 1) begin
          eng_rdy_m <= 1'b0; cnt <= busy_time; ph <= 2;
        end else cnt <= cnt - 1;
        default: if (cnt <= 1) begin
          eng_rdy_m <= 1'b1;
          ph        <= 0;
          if (eng_res_q.size() > 0) eng_result <= eng_res_q.pop_front();
          else eng_result <= {9'b0, eng_x};
        end else cnt <= cnt - 1;
      endcase
    end
  end

  // Monitors: start pulse count/width, operand stability, popped results.
  int          start_cnt = 0;
  int          start_run = 0;
  int          start_max = 0;
  int          stab_err  = 0;
  logic [7:0]  lx = 8'h00;
  logic [7:0]  ly = 8'h00;
  logic [16:0] got[$];

  always @(posedge clk) begin
    if (eng_start) begin
      start_run++;
      if (start_run > start_max) start_max = start_run;
      if (start_run == 1) begin
        start_cnt++;
        lx = eng_x;
        ly = eng_y;
      end
    end else begin
      start_run = 0;
      if (busy && (eng_x !== lx || eng_y !== ly)) stab_err++;
    end
    if (res_valid && res_ready) got.push_back(res_data);
  end

  function automatic logic [16:0] gres(input int i);
    return (got.size() > i) ? got[i] : 17'bx;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    start_cnt = 0;
    start_max = 0;
    stab_err  = 0;
    got.delete();
  endtask

  task automatic push_job(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    while (!job_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!job_ready) chk("push_timeout", {31'b0, job_ready}, 32'd1);
    job_valid = 1'b1;
    job_x     = x;
    job_y     = y;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_res(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("res_count", got.size(), n);
  endtask

  initial begin
    int n;
    tick(3);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_x", eng_x, 0);
    chk("rst_eng_y", eng_y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_jobs_done", jobs_done, 0);
    rst = 1'b1;
    tick(2);

    // single job: N+2 launch, one-cycle start, stable operands
    clear_mon();
    busy_time = 20;
    res_ready = 1'b1;
    eng_res_q.push_back(17'h00123);
    push_job(8'h05, 8'h10);
    chk("t1_start_n1", eng_start, 0);
    tick(1);
    chk("t1_start_n2", eng_start, 1);
    chk("t1_eng_x", eng_x, 8'h05);
    chk("t1_eng_y", eng_y, 8'h10);
    tick(1);
    chk("t1_start_fall", eng_start, 0);
    wait_res(1, 100);
    chk("t1_starts", start_cnt, 1);
    chk("t1_start_width", start_max, 1);
    chk("t1_stable", stab_err, 0);
    chk("t1_result", gres(0), 17'h00123);
    chk("t1_jobs_done", jobs_done, 1);
    chk("t1_x_held", eng_x, 8'h05);

    // queue full with the engine held not-ready
    clear_mon();
    busy_time = 3;
    eng_hold  = 1'b1;
    for (int i = 1; i <= 4; i++) push_job(8'(i), 8'h20);
    chk("t2_ready_full", job_ready, 0);
    job_valid = 1'b1;
    job_x     = 8'h55;
    job_y     = 8'h21;
    tick(5);
    chk("t2_still_full", job_ready, 0);
    chk("t2_no_launch", start_cnt, 0);
    chk("t2_idle", busy, 0);
    eng_hold = 1'b0;
    n = 0;
    while (!job_ready && n < 50) begin
      tick(1);
      n++;
    end
    chk("t2_reopen", job_ready, 1);
    tick(1);
    job_valid = 1'b0;
    wait_res(5, 300);
    for (int i = 0; i < 4; i++) chk("t2_order", gres(i), 17'(i + 1));
    chk("t2_fifth", gres(4), 17'h00055);
    chk("t2_jobs_done", jobs_done, 6);

    // result back-pressure over 6 jobs, signed results preserved
    clear_mon();
    res_ready = 1'b0;
    eng_res_q.push_back(17'h00005);
    eng_res_q.push_back(17'h1FFFD);
    eng_res_q.push_back(17'h00007);
    eng_res_q.push_back(17'h1FF9C);
    eng_res_q.push_back(17'h00009);
    eng_res_q.push_back(17'h0000B);
    for (int i = 0; i < 6; i++) push_job(8'(8'h30 + i), 8'h00);
    tick(60);
    chk("t3_launches", start_cnt, 4);
    chk("t3_res_valid", res_valid, 1);
    chk("t3_head", res_data, 17'h00005);
    chk("t3_stalled", busy, 0);
    res_ready = 1'b1;
    wait_res(6, 300);
    chk("t3_r0", gres(0), 17'h00005);
    chk("t3_r1_neg3", gres(1), 17'h1FFFD);
    chk("t3_r2", gres(2), 17'h00007);
    chk("t3_r3_neg100", gres(3), 17'h1FF9C);
    chk("t3_r4", gres(4), 17'h00009);
    chk("t3_r5", gres(5), 17'h0000B);
    chk("t3_launches_all", start_cnt, 6);
    chk("t3_jobs_done", jobs_done, 12);

    // slow acknowledge: engine keeps ready high 5 cycles after start
    clear_mon();
    ack_delay = 5;
    busy_time = 4;
    eng_res_q.push_back(17'h0ABCD);
    push_job(8'h77, 8'h01);
    tick(1);
    chk("t4_start", eng_start, 1);
    tick(3);
    chk("t4_start_low", eng_start, 0);
    chk("t4_busy", busy, 1);
    chk("t4_eng_ready", eng_ready, 1);
    chk("t4_no_result", got.size(), 0);
    wait_res(1, 100);
    chk("t4_starts", start_cnt, 1);
    chk("t4_start_width", start_max, 1);
    chk("t4_stable", stab_err, 0);
    chk("t4_result", gres(0), 17'h0ABCD);
    ack_delay = 0;

    // reset while in WAIT_DONE
    clear_mon();
    busy_time = 30;
    push_job(8'h99, 8'h02);
    tick(10);
    chk("t5_pre_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_eng_start", eng_start, 0);
    chk("t5_eng_x", eng_x, 0);
    chk("t5_eng_y", eng_y, 0);
    chk("t5_busy", busy, 0);
    chk("t5_jobs_done", jobs_done, 0);
    chk("t5_job_ready", job_ready, 1);
    chk("t5_res_valid", res_valid, 0);
    chk("t5_res_data", res_data, 0);
    tick(2);
    rst = 1'b1;
    tick(60);
    chk("t5_no_result", got.size(), 0);
    busy_time = 5;
    eng_res_q.push_back(17'h1F000);
    push_job(8'h42, 8'h03);
    wait_res(1, 100);
    chk("t5_next_result", gres(0), 17'h1F000);
    chk("t5_next_done", jobs_done, 1);

    // 257 jobs from reset: counter wraps to 1
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    clear_mon();
    busy_time = 1;
    for (int i = 0; i < 257; i++) push_job(8'(i), 8'h00);
    wait_res(257, 5000);
    chk("t6_jobs_done_wrap", jobs_done, 1);
    chk("t6_starts", start_cnt, 257);
    chk("t6_r255", gres(255), 17'h000FF);
    chk("t6_r256", gres(256), 17'h00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
